// File: rtl/acacia_arb_pkg.sv
// Shared helpers for the acacia round-robin arbiter: derived widths, the
// fairness bound and a one-hot to index decoder.
package acacia_arb_pkg;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned hold_width(input int unsigned max_hold);
      return $clog2(max_hold + 1);
   endfunction

   // Worst-case cycles from a persistent request to its grant.
   function automatic int unsigned fair_bound(input int unsigned n,
                                              input int unsigned max_hold);
      return (n - 1) * max_hold + 1;
   endfunction

   function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/acacia_rr_pick.sv
// Combinational round-robin search: first requester after i_ptr, wrapping
// modulo N, found by rotating the request vector and priority-encoding it.
module acacia_rr_pick
   import acacia_arb_pkg::*;
#(
   parameter int unsigned N   = 3,
   parameter int unsigned IDW = idx_width(N)
) (
   input  logic [N-1:0]   i_r,
   input  logic [IDW-1:0] i_ptr,
   output logic           o_found,
   output logic [IDW-1:0] o_j
);

   logic [IDW-1:0]   w_start;
   logic [2*N-1:0]   w_dbl;
   logic [N-1:0]     w_rot;
   logic [IDW-1:0]   w_k;
   logic [IDW:0]     w_sum;

   assign w_start = (i_ptr == IDW'(N - 1)) ? '0 : i_ptr + IDW'(1);
   assign w_dbl   = {i_r, i_r};
   // w_rot[k] is the request of client (w_start + k) mod N.
   assign w_rot   = N'(w_dbl >> w_start);
   assign o_found = |i_r;

   always_comb begin
      w_k = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) w_k = IDW'(k);
      end
   end

   assign w_sum = {1'b0, w_start} + {1'b0, w_k};
   assign o_j   = (w_sum >= (IDW + 1)'(N)) ? IDW'(w_sum - (IDW + 1)'(N)) : w_sum[IDW-1:0];

endmodule

// File: rtl/acacia_rr_arbiter.sv
// N-client round-robin arbiter with registered grants and a tenure limit.
// Define ACACIA_ARB_PARK_EN to park the grant on the last holder when idle.
module acacia_rr_arbiter
   import acacia_arb_pkg::*;
#(
   parameter int unsigned N        = 3,
   parameter int unsigned MAX_HOLD = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            r,
   output logic [N-1:0]            a,
   output logic                    a_valid,
   output logic [idx_width(N)-1:0] a_id
);

   localparam int unsigned IDW = idx_width(N);
   localparam int unsigned HCW = hold_width(MAX_HOLD);

   logic [N-1:0]   r_a;
   logic           r_valid;
   logic [IDW-1:0] r_id;
   logic [IDW-1:0] r_ptr;
   logic [HCW-1:0] r_hold;

   logic [N-1:0]   w_a_d;
   logic           w_valid_d;
   logic [IDW-1:0] w_id_d;
   logic [IDW-1:0] w_ptr_d;
   logic [HCW-1:0] w_hold_d;
   logic           w_found;
   logic [IDW-1:0] w_j;
   logic           w_keep;

   acacia_rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .i_r     (r),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_j     (w_j)
   );

   // A parked grant has r_hold=0, so a re-raised request there also takes this path.
   assign w_keep = r_valid && r[r_id] && (r_hold < HCW'(MAX_HOLD));

   always_comb begin
      w_a_d     = r_a;
      w_valid_d = r_valid;
      w_id_d    = r_id;
      w_ptr_d   = r_ptr;
      w_hold_d  = r_hold;
      if (w_keep) begin
         w_hold_d = r_hold + HCW'(1);
      end else if (w_found) begin
         w_a_d      = '0;
         w_a_d[w_j] = 1'b1;
         w_valid_d  = 1'b1;
         w_id_d     = w_j;
         w_ptr_d    = w_j;
         w_hold_d   = HCW'(1);
      end else begin
`ifdef ACACIA_ARB_PARK_EN
         w_hold_d = '0;
`else
         w_a_d     = '0;
         w_valid_d = 1'b0;
         w_id_d    = '0;
         w_hold_d  = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_valid <= 1'b0;
         r_id    <= '0;
         r_ptr   <= IDW'(N - 1);
         r_hold  <= '0;
      end else begin
         r_a     <= w_a_d;
         r_valid <= w_valid_d;
         r_id    <= w_id_d;
         r_ptr   <= w_ptr_d;
         r_hold  <= w_hold_d;
      end
   end

   assign a       = r_a;
   assign a_valid = r_valid;
   assign a_id    = r_id;

   a_onehot : assert property (@(posedge clk) $onehot0(r_a));
   a_valid_or : assert property (@(posedge clk) r_valid == (|r_a));
   a_id_match : assert property (@(posedge clk)
      r_id == (r_valid ? IDW'(onehot_to_idx(32'(r_a))) : IDW'(0)));

endmodule

// File: tb/tb_acacia_rr_arbiter.sv
// Directed checks on a 3-client arbiter plus a randomised 5-client run
// checking exclusivity, index consistency and the fairness bound.
module tb_acacia_rr_arbiter;
   import acacia_arb_pkg::*;

   localparam int unsigned BOUND5 = fair_bound(5, 1);

   logic       clk = 1'b0;
   logic       rst3, rst5;
   logic [2:0] r3;
   logic [2:0] a3;
   logic       v3;
   logic [1:0] id3;
   logic [4:0] r5;
   logic [4:0] a5;
   logic       v5;
   logic [2:0] id5;

   int n_checks = 0;
   int n_fail   = 0;
   int w5 [5];

   always #5 clk = ~clk;

   acacia_rr_arbiter #(
      .N        (3),
      .MAX_HOLD (2)
   ) dut3 (
      .clk     (clk),
      .rst     (rst3),
      .r       (r3),
      .a       (a3),
      .a_valid (v3),
      .a_id    (id3)
   );

   acacia_rr_arbiter #(
      .N        (5),
      .MAX_HOLD (1)
   ) dut5 (
      .clk     (clk),
      .rst     (rst5),
      .r       (r5),
      .a       (a5),
      .a_valid (v5),
      .a_id    (id5)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check3(input string tag, input logic [2:0] ea, input logic ev,
                         input logic [1:0] eid);
      check({tag, ".a"}, 32'(a3), 32'(ea));
      check({tag, ".valid"}, 32'(v3), 32'(ev));
      check({tag, ".id"}, 32'(id3), 32'(eid));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset3();
      rst3 = 1'b1;
      tick();
      rst3 = 1'b0;
   endtask

   logic [2:0] seq_a  [7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
   logic [1:0] seq_id [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};

   initial begin
      rst3 = 1'b1;
      rst5 = 1'b1;
      r3   = 3'b111;
      r5   = '0;
      tick();
      check3("reset", 3'b000, 1'b0, 2'd0);

      // Rotation under full load
      rst3 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check3($sformatf("rot%0d", i), seq_a[i], 1'b1, seq_id[i]);
      end

      // Sole requester is re-granted with no bubble
      r3 = 3'b000;
      reset3();
      r3 = 3'b010;
      for (int i = 0; i < 6; i++) begin
         tick();
         check3($sformatf("sole%0d", i), 3'b010, 1'b1, 2'd1);
      end
      r3 = 3'b000;
      tick();
`ifdef ACACIA_ARB_PARK_EN
      check3("sole_release", 3'b010, 1'b1, 2'd1);
`else
      check3("sole_release", 3'b000, 1'b0, 2'd0);
`endif

      // Holder drops early; pointer moves to client 2
      reset3();
      r3 = 3'b001;
      tick();
      check3("drop_g0", 3'b001, 1'b1, 2'd0);
      r3 = 3'b100;
      tick();
      check3("drop_g2", 3'b100, 1'b1, 2'd2);
      r3 = 3'b011;
      tick();
      check3("drop_wrap0", 3'b001, 1'b1, 2'd0);
      tick();
      check3("drop_hold0", 3'b001, 1'b1, 2'd0);
      tick();
      check3("drop_next1", 3'b010, 1'b1, 2'd1);

      // Reset mid-tenure
      reset3();
      r3 = 3'b111;
      tick();
      tick();
      tick();
      check3("mid_pre", 3'b010, 1'b1, 2'd1);
      rst3 = 1'b1;
      tick();
      check3("mid_rst", 3'b000, 1'b0, 2'd0);
      rst3 = 1'b0;
      tick();
      check3("mid_after", 3'b001, 1'b1, 2'd0);

`ifdef ACACIA_ARB_PARK_EN
      // Parking behaviour
      r3 = 3'b000;
      reset3();
      tick();
      check3("park_idle", 3'b000, 1'b0, 2'd0);
      r3 = 3'b010;
      tick();
      check3("park_g1", 3'b010, 1'b1, 2'd1);
      r3 = 3'b000;
      tick();
      check3("park_hold1", 3'b010, 1'b1, 2'd1);
      tick();
      check3("park_hold1b", 3'b010, 1'b1, 2'd1);
      r3 = 3'b001;
      tick();
      check3("park_move0", 3'b001, 1'b1, 2'd0);
      r3 = 3'b000;
      tick();
      check3("park_on0", 3'b001, 1'b1, 2'd0);
      r3 = 3'b011;
      tick();
      check3("park_regrant0", 3'b001, 1'b1, 2'd0);
      tick();
      check3("park_keep0", 3'b001, 1'b1, 2'd0);
      tick();
      check3("park_rot1", 3'b010, 1'b1, 2'd1);
`endif

      // Randomised 5-client run
      r3   = 3'b000;
      r5   = '0;
      rst5 = 1'b1;
      tick();
      check("rst5.a", 32'(a5), 32'd0);
      rst5 = 1'b0;
      for (int i = 0; i < 5; i++) w5[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         int pop;
         int idx;
         r5 = 5'($urandom) | 5'($urandom);
         tick();
         pop = 0;
         idx = 0;
         for (int i = 0; i < 5; i++) begin
            if (a5[i]) begin
               pop++;
               idx = i;
            end
         end
         if (pop > 1 || v5 !== (pop == 1) || id5 !== 3'(idx)) begin
            check("r5.consistency", {a5, v5, id5}, {a5, 1'b1, 3'(idx)});
         end
         for (int i = 0; i < 5; i++) begin
            if (r5[i] && !a5[i]) w5[i]++;
            else w5[i] = 0;
            if (w5[i] >= int'(BOUND5)) begin
               check($sformatf("r5.fair%0d", i), 32'(w5[i]), 32'(BOUND5 - 1));
               w5[i] = 0;
            end
         end
      end
      check("r5.end_onehot", 32'($countones(a5) <= 1), 32'd1);
      check("r5.end_valid", 32'(v5), 32'(|a5));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/acacia_rr_arbiter.md
Name: acacia_rr_arbiter

Overview:
- Parametrised N-client request/grant arbiter. Successor to the fixed 3-client synthesised arbiter in the acacia demo set.
- Guarantees the same properties in generalised form:
  - mutual exclusion of grants;
  - every persistent request is granted within a bounded number of cycles.
- Adds a synchronous reset, round-robin fairness, bounded grant hold (tenure limit) and an encoded grant index.
- Sits between N requesting agents and one shared resource. Grants are registered (Moore) outputs.

Parameters:
- N, 3, number of clients (2..32).
- MAX_HOLD, 2, maximum consecutive cycles one holder keeps the grant while others wait (>=1).
- IDW, $clog2(N), width of the encoded grant index (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- r  input  N  level request per client; r[i] is client i.
- a  output  N  one-hot or zero grant vector, registered.
- a_valid  output  1  OR of a, registered.
- a_id  output  IDW  index of the granted client; 0 when a_valid=0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: when rst=1 at a posedge:
  - a=0, a_valid=0, a_id=0;
  - ptr=N-1, so client 0 has first priority;
  - hold_cnt=0.
  - rst overrides all requests in that cycle; reset mid-tenure drops the grant at that edge.
- Invariant: popcount(a)<=1 in every cycle. a_valid==|a. a_id==index of the set bit.
- Latency: r sampled at posedge t drives a after posedge t, i.e. 1 cycle. There is no combinational path r->a.
- States:
  - IDLE: a=0.
  - GRANT(i): a[i]=1.
  - The state is carried by the a/ptr/hold_cnt registers.
- Next-state rule, evaluated each posedge when rst=0:
  1. Hold: if in GRANT(h), r[h]=1 and hold_cnt<MAX_HOLD, keep GRANT(h) and increment hold_cnt.
  2. Otherwise, search clients ptr+1, ptr+2, ..., ptr+N (mod N) and take the first j with r[j]=1:
     - enter GRANT(j), set ptr=j, set hold_cnt=1.
     - j may equal h. A sole requester is re-granted back-to-back with no idle bubble.
  3. If no requester is found, enter IDLE, set hold_cnt=0, and leave ptr unchanged.
- Holder drops r[h]: the grant moves at the next edge to the next requester, or to IDLE.
- Fairness bound: a client holding r high continuously receives a within (N-1)*MAX_HOLD+1 cycles.
- Widths:
  - hold_cnt is $clog2(MAX_HOLD+1) bits and saturates logically via rule 1; it never wraps.
  - ptr arithmetic is modulo N, which must be correct for non-power-of-two N.
- MAX_HOLD=1 degenerates to pure per-cycle rotation.

Optional Feature:
- Macro: ACACIA_ARB_PARK_EN.
- With the macro: rule 3 does not enter IDLE. The grant parks on client ptr:
  - a stays asserted on ptr, a_valid=1, hold_cnt=0.
  - If r[ptr] rises while parked, the next edge sets hold_cnt=1; that is treated as a new grant.
  - After reset (ptr=N-1) the block is still IDLE until the first grant occurs.
- Without the macro: behaviour exactly as in rule 3 (IDLE, a=0).

Decomposition:
- Package acacia_arb_pkg holds:
  - an onehot-to-index function;
  - the localparam helpers for IDW and the hold_cnt width;
  - the fairness-bound constant expression used by assertions.
- One sub-module, acacia_rr_pick:
  - purely combinational;
  - inputs r and ptr; outputs found and index j;
  - uses a rotate-and-priority-encode scheme.
- The top holds all registers and the hold logic.

Test Plan:
All scenarios use N=3, MAX_HOLD=2 unless stated.
1. Reset, then r=3'b111 held -> a sequence, one cycle per line:
   - 001 for 2 cycles;
   - 010 for 2 cycles;
   - 100 for 2 cycles;
   - 001 again.
   - a_id follows 0,0,1,1,2,2,0.
2. Only r=3'b010 held for 6 cycles -> a=010 every cycle after the first edge, with no gap; then r=0 -> a=000 and a_valid=0 the next cycle.
3. Holder 0 granted, r[0] drops after 1 cycle while r[2]=1 -> a=100 at the next edge, ptr=2; later r=3'b011 -> a=001 first.
4. rst asserted while a=010 with r=3'b111 -> a=000 at that edge; after release, a=001 first (priority restarts at client 0).
5. N=5, MAX_HOLD=1, random r, 10k cycles -> assertions:
   - popcount(a)<=1;
   - a_id consistent with a;
   - every continuously high r[i] is granted within 5 cycles.
6. Build with ACACIA_ARB_PARK_EN, grant client 1, then r=0 -> a stays 010 with a_valid=1; then r=3'b001 -> a=001 next edge.
